// File: rtl/csr_types.sv
// CSR-level types shared by the MMU blocks: PTE permission bits and privilege levels.
package csr_types;

   // Bit order matches the low byte of a RISC-V PTE (v at bit 0, d at bit 7).
   typedef struct packed {
      logic d;
      logic a;
      logic g;
      logic u;
      logic x;
      logic w;
      logic r;
      logic v;
   } pte_perms_t;

   typedef enum logic [1:0] {
      USER       = 2'b00,
      SUPERVISOR = 2'b01,
      MACHINE    = 2'b11
   } privilege_t;

endpackage

// File: rtl/mmu_types.sv
// MMU-side types: access kinds, page-fault exception codes and the permission-check FSM states.
package mmu_types;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } access_type_t;

   localparam logic [4:0] INST_PAGE_FAULT  = 5'd12;
   localparam logic [4:0] LOAD_PAGE_FAULT  = 5'd13;
   localparam logic [4:0] STORE_PAGE_FAULT = 5'd15;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StResp,
      StUpdate,
      StWaitAck
   } perms_state_t;

   function automatic logic [4:0] page_fault_code(access_type_t acc);
      case (acc)
         FETCH:   return INST_PAGE_FAULT;
         LOAD:    return LOAD_PAGE_FAULT;
         default: return STORE_PAGE_FAULT;
      endcase
   endfunction

endpackage

// File: rtl/perms_check_logic.sv
// Combinational PTE permission evaluation: privilege/access legality and missing A/D bits.
module perms_check_logic
   import csr_types::*;
   import mmu_types::*;
(
   input  pte_perms_t   perms,
   input  access_type_t access,
   input  logic         mxr,
   input  logic         sum,
   input  privilege_t   privilege,
   output logic         priv_ok,
   output logic         type_ok,
   output logic         need_a,
   output logic         need_d
);

   always_comb begin
      priv_ok = 1'b0;
      case (privilege)
         MACHINE:    priv_ok = 1'b1;
         SUPERVISOR: priv_ok = ~perms.u | sum;
         USER:       priv_ok = perms.u;
         default:    priv_ok = 1'b0;
      endcase
   end

   always_comb begin
      type_ok = 1'b0;
      case (access)
         FETCH:   type_ok = perms.x;
         LOAD:    type_ok = perms.r | (perms.x & mxr);
         STORE:   type_ok = perms.w;
         default: type_ok = 1'b0;
      endcase
   end

   assign need_a = ~perms.a;
   assign need_d = (access == STORE) & ~perms.d;

   logic unused_bits;
   assign unused_bits = perms.v ^ perms.g;

endmodule

// File: rtl/perms_check_unit.sv
// Shared round-robin PTE permission checker with page-fault codes.
// Define CVA5_PERMS_SVADU_EN to enable hardware A/D-bit updates through the walker port.
module perms_check_unit
   import csr_types::*;
   import mmu_types::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic         [NUM_PORTS-1:0]  req_valid,
   output logic         [NUM_PORTS-1:0]  req_ready,
   input  pte_perms_t   [NUM_PORTS-1:0]  req_perms,
   input  access_type_t [NUM_PORTS-1:0]  req_type,
   input  logic                          mxr,
   input  logic                          sum,
   input  privilege_t                    privilege,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic         [PORT_W-1:0]     rsp_port,
   output logic                          rsp_fault,
   output logic         [4:0]            rsp_code,
   output pte_perms_t                    rsp_perms,
   output logic                          upd_valid,
   input  logic                          upd_ready,
   output pte_perms_t                    upd_perms,
   input  logic                          upd_ack,
   input  logic                          upd_err
);

   perms_state_t      state_q, state_d;
   logic [PORT_W-1:0] ptr_q, port_q, gnt_idx, cand, ptr_next;
   logic              gnt_found, accept;
   pte_perms_t        perms_q;
   access_type_t      type_q;
   logic              mxr_q, sum_q;
   privilege_t        priv_q;
   logic              fault_q;
   logic [4:0]        code_q;
   logic              priv_ok, type_ok, need_a, need_d;
   logic              chk_pass, need_upd, check_fault;

   // First requester at or after the round-robin pointer wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cand = PORT_W'((32'(ptr_q) + i) % NUM_PORTS);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign accept    = (state_q == StIdle) && gnt_found;
   assign req_ready = (accept && !rst) ? (NUM_PORTS'(1) << gnt_idx) : '0;
   assign ptr_next  = (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

   perms_check_logic u_check (
      .perms     (perms_q),
      .access    (type_q),
      .mxr       (mxr_q),
      .sum       (sum_q),
      .privilege (priv_q),
      .priv_ok   (priv_ok),
      .type_ok   (type_ok),
      .need_a    (need_a),
      .need_d    (need_d)
   );

   assign chk_pass = priv_ok & type_ok;
   assign need_upd = need_a | need_d;
`ifdef CVA5_PERMS_SVADU_EN
   assign check_fault = ~chk_pass;
`else
   assign check_fault = ~chk_pass | need_upd;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StCheck;
`ifdef CVA5_PERMS_SVADU_EN
         StCheck: state_d = (chk_pass && need_upd) ? StUpdate : StResp;
         StUpdate:  if (upd_ready) state_d = StWaitAck;
         StWaitAck: if (upd_ack) state_d = StResp;
`else
         StCheck: state_d = StResp;
`endif
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

`ifdef CVA5_PERMS_SVADU_EN
   pte_perms_t upd_calc, upd_perms_q;

   always_comb begin
      upd_calc   = perms_q;
      upd_calc.a = 1'b1;
      if (need_d) upd_calc.d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) upd_perms_q <= '0;
      else if (state_q == StCheck) upd_perms_q <= upd_calc;
   end

   assign upd_valid = (state_q == StUpdate);
   assign upd_perms = upd_perms_q;
`else
   assign upd_valid = 1'b0;
   assign upd_perms = '0;

   logic unused_upd;
   assign unused_upd = upd_ready ^ upd_ack ^ upd_err;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         port_q  <= '0;
         perms_q <= '0;
         type_q  <= FETCH;
         mxr_q   <= 1'b0;
         sum_q   <= 1'b0;
         priv_q  <= USER;
         fault_q <= 1'b0;
         code_q  <= '0;
      end else begin
         if (accept) begin
            ptr_q   <= ptr_next;
            port_q  <= gnt_idx;
            perms_q <= req_perms[gnt_idx];
            type_q  <= req_type[gnt_idx];
            mxr_q   <= mxr;
            sum_q   <= sum;
            priv_q  <= privilege;
         end
         if (state_q == StCheck) begin
            fault_q <= check_fault;
            code_q  <= check_fault ? page_fault_code(type_q) : 5'd0;
         end
`ifdef CVA5_PERMS_SVADU_EN
         if (state_q == StWaitAck && upd_ack) begin
            if (upd_err) begin
               fault_q <= 1'b1;
               code_q  <= page_fault_code(type_q);
            end else begin
               perms_q <= upd_perms_q;
            end
         end
`endif
      end
   end

   assign rsp_valid = (state_q == StResp);
   assign rsp_port  = port_q;
   assign rsp_fault = fault_q;
   assign rsp_code  = code_q;
   assign rsp_perms = perms_q;

endmodule

// File: tb/tb_perms_check_unit.sv
// Self-checking bench for perms_check_unit: directed cases plus randomized requests vs. a rule model.
module tb_perms_check_unit;
   import csr_types::*;
   import mmu_types::*;

   localparam int NP = 2;
   localparam int PW = 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic         [NP-1:0]   req_valid, req_ready;
   pte_perms_t   [NP-1:0]   req_perms;
   access_type_t [NP-1:0]   req_type;
   logic                    mxr, sum;
   privilege_t              privilege;
   logic                    rsp_valid, rsp_ready, rsp_fault;
   logic         [PW-1:0]   rsp_port;
   logic         [4:0]      rsp_code;
   pte_perms_t              rsp_perms, upd_perms;
   logic                    upd_valid, upd_ready, upd_ack, upd_err;

   int n_tests = 0;
   int n_fail  = 0;

   perms_check_unit #(.NUM_PORTS(NP)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_perms (req_perms),
      .req_type  (req_type),
      .mxr       (mxr),
      .sum       (sum),
      .privilege (privilege),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_port  (rsp_port),
      .rsp_fault (rsp_fault),
      .rsp_code  (rsp_code),
      .rsp_perms (rsp_perms),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_perms (upd_perms),
      .upd_ack   (upd_ack),
      .upd_err   (upd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: permission rules of the privileged spec, perms as a PTE byte (r=1,w=2,x=3,u=4,a=6,d=7).
   function automatic void model(input logic [7:0] p, input int typ, input bit m, input bit s,
                                 input int pv, input bit uerr, output bit f, output logic [4:0] c,
                                 output logic [7:0] rp, output bit upd, output logic [7:0] up);
      int  codes[3] = '{12, 13, 15};
      bit  allowed, needs;
      if (pv == 3)      allowed = 1'b1;
      else if (pv == 1) allowed = !p[4] || s;
      else              allowed = p[4];
      if (typ == 0)      allowed = allowed && p[3];
      else if (typ == 1) allowed = allowed && (p[1] || (p[3] && m));
      else               allowed = allowed && p[2];
      needs = !p[6] || (typ == 2 && !p[7]);
      up    = p | 8'h40 | ((typ == 2) ? 8'h80 : 8'h00);
      rp    = p;
      upd   = 1'b0;
      if (!allowed) f = 1'b1;
      else if (needs) begin
`ifdef CVA5_PERMS_SVADU_EN
         upd = 1'b1;
         f   = uerr;
         if (!uerr) rp = up;
`else
         f = 1'b1;
`endif
      end else f = 1'b0;
      c = f ? 5'(codes[typ]) : 5'd0;
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_port",  32'(rsp_port),  0);
      chk("rst_rsp_fault", 32'(rsp_fault), 0);
      chk("rst_rsp_code",  32'(rsp_code),  0);
      chk("rst_rsp_perms", 32'(rsp_perms), 0);
      chk("rst_upd_valid", 32'(upd_valid), 0);
      chk("rst_upd_perms", 32'(upd_perms), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One request from an idle unit; acts as walker and consumer. Starts and ends on a negedge.
   task automatic run_req(input int port, input logic [7:0] p, input int typ, input bit m,
                          input bit s, input int pv, input int rdy_dly, input int ack_dly,
                          input bit uerr, input int hold);
      bit         ef, eupd, seen;
      logic [4:0] ec;
      logic [7:0] ep, eup;
      int         lat;
      model(p, typ, m, s, pv, uerr, ef, ec, ep, eupd, eup);
      req_valid       = '0;
      req_valid[port] = 1'b1;
      req_perms[port] = pte_perms_t'(p);
      req_type[port]  = access_type_t'(typ);
      mxr             = m;
      sum             = s;
      privilege       = privilege_t'(pv);
      #1;
      chk("grant", 32'(req_ready), 1 << port);
      @(negedge clk);
      // Scramble inputs after accept; the unit must use the sampled values.
      req_valid       = '0;
      req_perms[port] = pte_perms_t'(~p);
      mxr             = ~m;
      sum             = ~s;
      privilege       = USER;
      lat             = 1;
      seen            = 1'b0;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         if (upd_valid === 1'b1 && !seen) begin
            seen = 1'b1;
            chk("upd_perms", 32'(upd_perms), 32'(eup));
            repeat (rdy_dly) @(negedge clk);
            chk("upd_hold", 32'(upd_valid), 1);
            upd_ready = 1'b1;
            @(negedge clk);
            upd_ready = 1'b0;
            repeat (ack_dly - 1) @(negedge clk);
            upd_ack = 1'b1;
            upd_err = uerr;
            @(negedge clk);
            upd_ack = 1'b0;
            upd_err = 1'b0;
            lat += rdy_dly + ack_dly + 1;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("upd_seen", 32'(seen), 32'(eupd));
      if (!eupd) chk("latency", lat, 2);
      chk("rsp_fault", 32'(rsp_fault), 32'(ef));
      chk("rsp_code",  32'(rsp_code),  32'(ec));
      chk("rsp_perms", 32'(rsp_perms), 32'(ep));
      chk("rsp_port",  32'(rsp_port),  port);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 1);
         chk("hold_code",  32'(rsp_code),  32'(ec));
         chk("hold_perms", 32'(rsp_perms), 32'(ep));
         chk("hold_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", 32'(rsp_valid), 0);
   endtask

   initial begin
      int pvs[3] = '{0, 1, 3};
      int lat;
      rst       = 1'b1;
      req_valid = '0;
      req_perms = '0;
      req_type  = {NP{FETCH}};
      mxr       = 1'b0;
      sum       = 1'b0;
      privilege = USER;
      rsp_ready = 1'b0;
      upd_ready = 1'b0;
      upd_ack   = 1'b0;
      upd_err   = 1'b0;
      reset_dut();

      // USER load r,u,a: pass in two cycles.
      run_req(0, 8'h52, 1, 1'b0, 1'b0, 0, 0, 1, 1'b0, 0);
      // SUPERVISOR store to a user page without SUM: store page fault.
      run_req(1, 8'hD4, 2, 1'b0, 1'b0, 1, 0, 1, 1'b0, 1);
      // Execute-only page loaded with and without MXR.
      run_req(0, 8'h48, 1, 1'b1, 1'b0, 1, 0, 1, 1'b0, 0);
      run_req(1, 8'h48, 1, 1'b0, 1'b0, 1, 0, 1, 1'b0, 0);
      // Store with A and D clear: update path (or fault without Svadu), then walker error.
      run_req(0, 8'h04, 2, 1'b0, 1'b0, 3, 2, 3, 1'b0, 0);
      run_req(1, 8'h04, 2, 1'b0, 1'b0, 3, 2, 3, 1'b1, 0);
      // Fetch from a non-executable page.
      run_req(0, 8'h46, 0, 1'b0, 1'b0, 3, 0, 1, 1'b0, 0);

      // Both ports requesting continuously: grants alternate, response held while stalled.
      reset_dut();
      for (int i = 0; i < NP; i++) begin
         req_perms[i] = pte_perms_t'(8'h52);
         req_type[i]  = LOAD;
      end
      privilege = USER;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_grant", 32'(req_ready), (k % 2 == 1) ? 2 : 1);
         @(negedge clk);
         @(negedge clk);
         chk("rr_valid", 32'(rsp_valid), 1);
         chk("rr_port",  32'(rsp_port),  k % 2);
         repeat (3) begin
            @(negedge clk);
            chk("rr_hold_valid", 32'(rsp_valid), 1);
            chk("rr_hold_port",  32'(rsp_port),  k % 2);
            chk("rr_hold_fault", 32'(rsp_fault), 0);
            chk("rr_no_grant",   32'(req_ready), 0);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
      req_valid = '0;

      // Reset while in RESP: outputs clear, pointer returns to port 0.
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b11;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("resp_before_rst", 32'(rsp_valid), 1);
      reset_dut();
      #1;
      chk("grant_after_rst", 32'(req_ready), 1);
      req_valid = '0;
      @(negedge clk);

`ifdef CVA5_PERMS_SVADU_EN
      // Reset while waiting for the walker ack; a late ack must be ignored.
      req_valid    = 2'b10;
      req_perms[1] = pte_perms_t'(8'h04);
      req_type[1]  = STORE;
      privilege    = MACHINE;
      lat          = 0;
      @(negedge clk);
      req_valid = '0;
      while (upd_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("upd_before_rst", 32'(upd_valid), 1);
      upd_ready = 1'b1;
      @(negedge clk);
      upd_ready = 1'b0;
      req_valid = 2'b11;
      reset_dut();
      #1;
      chk("grant_after_rst2", 32'(req_ready), 1);
      req_valid = '0;
      upd_ack   = 1'b1;
      @(negedge clk);
      upd_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack_rsp", 32'(rsp_valid), 0);
      chk("stray_ack_upd", 32'(upd_valid), 0);
`endif

      // Randomized requests against the rule model.
      for (int n = 0; n < 40; n++) begin
         run_req($urandom_range(0, NP - 1), 8'($urandom_range(0, 255)), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pvs[$urandom_range(0, 2)],
                 $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
